// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcode/funct
// values and the mux/ALU select codes seen by both the controller and the datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_OR     = 3'b010;
    localparam logic [2:0] ALU_PASS_B = 3'b011;
    localparam logic [2:0] ALU_SLT    = 3'b100;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI   = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;

    // Unsupported opcodes fall straight back to FETCH, giving a two-cycle nop.
    function automatic state_e decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:      return S_EXEC_R;
            OP_ORI, OP_LUI: return S_EXEC_I;
            OP_LW, OP_SW:  return S_MEM_ADDR;
            OP_BEQ:        return S_BRANCH;
            OP_J:          return S_JUMP;
            default:       return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps the instruction's opcode/funct to the ALU operation used in the execute step.
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADDU: alu_op = ALU_ADD;
                FN_SUBU: alu_op = ALU_SUB;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else if (opcode == OP_ORI) begin
            alu_op = ALU_OR;
        end else if (opcode == OP_LUI) begin
            alu_op = ALU_PASS_B;
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS controller: one state register, all control outputs decoded
// combinationally from state, opcode, funct and the ALU zero flag.
module multi_cycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic [2:0]         alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         ext_op,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               instr_done,
    output logic [1:0]         pc_src,
    output logic [1:0]         reg_dst,
    output logic [STATE_W-1:0] state
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] exec_alu_op;

    alu_op_decode u_alu_op_decode (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (exec_alu_op)
    );

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign state = STATE_W'(state_q);

    always_comb begin
        state_d    = state_q;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_op     = EXT_ZERO;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        pc_src     = PC_ALU;
        reg_dst    = DST_RT;

        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b  = SRCB_BR;
                state_d    = decode_target(opcode);
                instr_done = (state_d == S_FETCH);
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RT;
                alu_op    = exec_alu_op;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = (opcode == OP_LUI) ? EXT_HI : EXT_ZERO;
                alu_op    = exec_alu_op;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = EXT_SIGN;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset wins over any instruction in flight and suppresses all write enables.
        if (reset) begin
            state_d    = S_FETCH;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: expected per-cycle control words are queued
// per instruction and popped/compared on each falling edge.
module tb_multi_cycle_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] ext;
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic       pc_write, ir_write, mem_write, reg_write, mem_to_reg, instr_done;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [3:0] state;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multi_cycle_control #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .state      (state)
    );

    function automatic ctl_t blank(input logic [3:0] s);
        ctl_t c;
        c = '0;
        c.st = s;
        return c;
    endfunction

    task automatic push(input ctl_t c, input string t);
        exp_q.push_back(c);
        tag_q.push_back(t);
    endtask

    task automatic push_fetch(input string t);
        ctl_t c;
        c = blank(4'd0);
        c.pc_write = 1'b1;
        c.ir_write = 1'b1;
        c.src_b    = 2'b01;
        push(c, {t, "_fetch"});
    endtask

    task automatic push_decode(input string t, input logic done);
        ctl_t c;
        c = blank(4'd1);
        c.src_b      = 2'b11;
        c.instr_done = done;
        push(c, {t, "_decode"});
    endtask

    task automatic check_one();
        ctl_t  obs;
        ctl_t  exp_c;
        string t;
        @(negedge clk);
        obs.st         = state;
        obs.alu_op     = alu_op;
        obs.src_a      = alu_src_a;
        obs.src_b      = alu_src_b;
        obs.ext        = ext_op;
        obs.pc_write   = pc_write;
        obs.ir_write   = ir_write;
        obs.mem_write  = mem_write;
        obs.reg_write  = reg_write;
        obs.mem_to_reg = mem_to_reg;
        obs.instr_done = instr_done;
        obs.pc_src     = pc_src;
        obs.reg_dst    = reg_dst;
        exp_c = exp_q.pop_front();
        t     = tag_q.pop_front();
        checks++;
        assert (obs === exp_c) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp_c);
        end
        $display("cycle %s state=%0d observed=%h expected=%h", t, state, obs, exp_c);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) check_one();
    endtask

    task automatic do_rtype(input logic [5:0] fn, input logic [2:0] aop, input string t);
        ctl_t c;
        opcode = 6'b000000; funct = fn; zero = 1'b0;
        push_fetch(t);
        push_decode(t, 1'b0);
        c = blank(4'd2); c.src_a = 1'b1; c.src_b = 2'b00; c.alu_op = aop;
        push(c, {t, "_exec"});
        c = blank(4'd7); c.reg_write = 1'b1; c.reg_dst = 2'b01; c.instr_done = 1'b1;
        push(c, {t, "_wb"});
        drain();
    endtask

    task automatic do_imm(input logic [5:0] op, input logic [1:0] ext, input logic [2:0] aop,
                          input string t);
        ctl_t c;
        opcode = op; funct = 6'b100011; zero = 1'b1;
        push_fetch(t);
        push_decode(t, 1'b0);
        c = blank(4'd3); c.src_a = 1'b1; c.src_b = 2'b10; c.ext = ext; c.alu_op = aop;
        push(c, {t, "_exec"});
        c = blank(4'd7); c.reg_write = 1'b1; c.reg_dst = 2'b00; c.instr_done = 1'b1;
        push(c, {t, "_wb"});
        drain();
    endtask

    task automatic push_mem_addr(input string t);
        ctl_t c;
        c = blank(4'd4); c.src_a = 1'b1; c.src_b = 2'b10; c.ext = 2'b01; c.alu_op = 3'b000;
        push(c, {t, "_addr"});
    endtask

    task automatic do_lw();
        ctl_t c;
        opcode = 6'b100011; funct = 6'b101010; zero = 1'b0;
        push_fetch("lw");
        push_decode("lw", 1'b0);
        push_mem_addr("lw");
        push(blank(4'd5), "lw_memrd");
        c = blank(4'd8); c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
        push(c, "lw_wb");
        drain();
    endtask

    task automatic do_sw();
        ctl_t c;
        opcode = 6'b101011; funct = 6'b000000; zero = 1'b0;
        push_fetch("sw");
        push_decode("sw", 1'b0);
        push_mem_addr("sw");
        c = blank(4'd6); c.mem_write = 1'b1; c.instr_done = 1'b1;
        push(c, "sw_memwr");
        drain();
    endtask

    task automatic do_beq(input logic z, input string t);
        ctl_t c;
        opcode = 6'b000100; funct = 6'b000000; zero = z;
        push_fetch(t);
        push_decode(t, 1'b0);
        c = blank(4'd9); c.src_a = 1'b1; c.src_b = 2'b00; c.alu_op = 3'b001;
        c.pc_src = 2'b01; c.pc_write = z; c.instr_done = 1'b1;
        push(c, {t, "_branch"});
        drain();
    endtask

    task automatic do_j();
        ctl_t c;
        opcode = 6'b000010; funct = 6'b000000; zero = 1'b1;
        push_fetch("j");
        push_decode("j", 1'b0);
        c = blank(4'd10); c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
        push(c, "j_jump");
        drain();
    endtask

    task automatic do_unknown(input logic [5:0] op, input string t);
        opcode = op; funct = 6'b100001; zero = 1'b0;
        push_fetch(t);
        push_decode(t, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t c;
        reset = 1'b1; opcode = 6'b000000; funct = 6'b000000; zero = 1'b0;
        @(posedge clk);
        #1;
        c = blank(4'd0); c.src_b = 2'b01;
        push(c, "reset_hold0");
        push(c, "reset_hold1");
        drain();
        reset = 1'b0;

        do_rtype(6'b100001, 3'b000, "addu");
        do_rtype(6'b100011, 3'b001, "subu");
        do_rtype(6'b101010, 3'b100, "slt");
        do_rtype(6'b000000, 3'b000, "rtype_other");
        do_imm(6'b001101, 2'b00, 3'b010, "ori");
        do_imm(6'b001111, 2'b10, 3'b011, "lui");
        do_lw();
        do_sw();
        do_beq(1'b1, "beq_taken");
        do_beq(1'b0, "beq_not_taken");
        do_j();
        do_unknown(6'b111111, "op_3f");
        do_unknown(6'b001000, "op_08");

        // Reset arriving mid-load, in MEM_RD, must abandon the load without a write-back.
        opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;
        push_fetch("rst_lw");
        push_decode("rst_lw", 1'b0);
        push_mem_addr("rst_lw");
        drain();
        reset = 1'b1;
        push(blank(4'd5), "rst_in_memrd");
        c = blank(4'd0); c.src_b = 2'b01;
        push(c, "rst_forced_fetch");
        drain();
        reset = 1'b0;
        do_rtype(6'b100001, 3'b000, "addu_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
